inst_sram_like_bridge_ot: RTL and testbench

Parametrised instruction-fetch bridge between the CPU fetch stage and the sram_like instruction bus, with multiple outstanding requests.
- CPU side: request channel (valid/ack) and response channel (valid/ready).
- Bus side: standard sram_like master (req/addr_ok/data_ok).
- Credit-limited in-order pipelining up to MAX_OUTSTANDING transactions.
- Flush discards every in-flight response without violating bus protocol.

---
 rtl/inst_bridge_pkg.sv | 17 +
 rtl/inst_sram_like_bridge_ot_sync_fifo.sv | 61 ++++++
 rtl/inst_sram_like_bridge_ot.sv | 115 +++++++++++
 tb/tb_inst_sram_like_bridge_ot.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_bridge_pkg.sv
// Shared constants and helpers for the sram_like instruction-fetch bridge.
package inst_bridge_pkg;

  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic       RST_ENABLE = 1'b0;

  // Ceiling log2 for sizing counters and pointers from elaboration-time values.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inst_sram_like_bridge_ot_sync_fifo.sv
// Synchronous FIFO with clear; clear wins over push and pop in the same cycle.
module sync_fifo
  import inst_bridge_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/inst_sram_like_bridge_ot.sv
// Instruction-fetch bridge from the CPU fetch stage to an sram_like bus,
// with credit-limited in-order pipelining and flush that drains killed replies.
module inst_sram_like_bridge_ot
  import inst_bridge_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_addr_ack,
  output logic               cpu_rvalid,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               cpu_rready,
  output logic               inst_stall,
  output logic               proto_err,
  output logic               inst_req,
  output logic               inst_wr,
  output logic [1:0]         inst_size,
  output logic [ADDR_W-1:0]  inst_addr,
  output logic [DATA_W-1:0]  inst_wdata,
  input  logic [DATA_W-1:0]  inst_rdata,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok
);

  localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1;

  logic             req_pend;
  logic             req_pend_next;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_cnt_next;
  logic [CNT_W-1:0] kill_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   in_use;
  logic             addr_hs;
  logic             data_hit;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign inst_req   = req_pend;
  assign inst_wr    = 1'b0;
  assign inst_size  = SIZE_WORD;
  assign inst_wdata = '0;

  // Credits cover the pending request, issued-but-unreturned beats and
  // buffered replies, so the response FIFO can never overflow.
  assign in_use = {1'b0, out_cnt} + {1'b0, fifo_cnt} + (CNT_W + 1)'(req_pend);

  assign cpu_addr_ack = cpu_req & ~req_pend & ~flush & (stall == '0)
                      & (in_use < (CNT_W + 1)'(MAX_OUTSTANDING));

  assign addr_hs  = req_pend & inst_addr_ok;
  assign data_hit = inst_data_ok & (out_cnt != '0);

  assign out_cnt_next  = out_cnt + CNT_W'(addr_hs) - CNT_W'(data_hit);
  assign req_pend_next = cpu_addr_ack | (req_pend & ~addr_hs);

  assign fifo_push  = data_hit & (kill_cnt == '0) & ~flush;
  assign fifo_pop   = cpu_rvalid & cpu_rready;
  assign cpu_rvalid = ~fifo_empty;
  assign inst_stall = cpu_rready & ~cpu_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      req_pend  <= 1'b0;
      inst_addr <= '0;
      out_cnt   <= '0;
      kill_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      req_pend <= req_pend_next;
      out_cnt  <= out_cnt_next;
      if (cpu_addr_ack) inst_addr <= cpu_addr;
      // Everything still owed by the bus after this cycle belongs to the old stream.
      if (flush) begin
        kill_cnt <= out_cnt_next + CNT_W'(req_pend_next);
      end else if (data_hit && (kill_cnt != '0)) begin
        kill_cnt <= kill_cnt - CNT_W'(1);
      end
      if (inst_data_ok && (out_cnt == '0)) proto_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata (inst_rdata),
    .rdata (cpu_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
    !(fifo_push && fifo_full && !fifo_pop && !flush));

  assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
    (inst_req && !inst_addr_ok && !cpu_addr_ack) |=> (inst_req && $stable(inst_addr)));

endmodule

// File: tb/tb_inst_sram_like_bridge_ot.sv
// Directed bench for the fetch bridge with a transaction-level reference model.
module tb_inst_sram_like_bridge_ot;

  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  stall;
  logic        flush;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_addr_ack;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_rready;
  logic        inst_stall;
  logic        proto_err;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_sram_like_bridge_ot #(
    .ADDR_W (32), .DATA_W (32), .MAX_OUTSTANDING (MAX_OUT), .STALL_W (4)
  ) dut (
    .clk (clk), .rst (rst), .stall (stall), .flush (flush),
    .cpu_req (cpu_req), .cpu_addr (cpu_addr), .cpu_addr_ack (cpu_addr_ack),
    .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata), .cpu_rready (cpu_rready),
    .inst_stall (inst_stall), .proto_err (proto_err),
    .inst_req (inst_req), .inst_wr (inst_wr), .inst_size (inst_size),
    .inst_addr (inst_addr), .inst_wdata (inst_wdata), .inst_rdata (inst_rdata),
    .inst_addr_ok (inst_addr_ok), .inst_data_ok (inst_data_ok)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one entry per bus transaction, tagged killed or live.
  bit          m_pend;
  bit          m_pend_killed;
  logic [31:0] m_pend_addr;
  bit          m_inflight[$];
  logic [31:0] m_rq[$];
  bit          m_perr;
  bit          m_exp_ack;
  bit          m_killed;

  task automatic modelReset();
    m_pend = 1'b0;
    m_pend_killed = 1'b0;
    m_pend_addr = '0;
    m_inflight.delete();
    m_rq.delete();
    m_perr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      modelReset();
      checkOutput("rst_inst_req", 32'(inst_req), 32'd0);
      checkOutput("rst_rvalid", 32'(cpu_rvalid), 32'd0);
      checkOutput("rst_proto_err", 32'(proto_err), 32'd0);
    end else begin
      m_exp_ack = cpu_req && !m_pend && !flush && (stall == 4'h0)
                  && (m_inflight.size() + m_rq.size() + int'(m_pend) < MAX_OUT);
      checkOutput("addr_ack", 32'(cpu_addr_ack), 32'(m_exp_ack));
      checkOutput("inst_req", 32'(inst_req), 32'(m_pend));
      checkOutput("inst_addr", inst_addr, m_pend_addr);
      checkOutput("rvalid", 32'(cpu_rvalid), 32'(m_rq.size() != 0));
      if (m_rq.size() != 0) checkOutput("rdata", cpu_rdata, m_rq[0]);
      checkOutput("proto_err", 32'(proto_err), 32'(m_perr));
      checkOutput("inst_stall", 32'(inst_stall), 32'(cpu_rready && (m_rq.size() == 0)));
      checkOutput("inst_size", 32'(inst_size), 32'd2);
      checkOutput("inst_wr_wdata", inst_wdata | 32'(inst_wr), 32'd0);

      if ((m_rq.size() != 0) && cpu_rready) void'(m_rq.pop_front());
      if (inst_data_ok) begin
        if (m_inflight.size() == 0) m_perr = 1'b1;
        else begin
          m_killed = m_inflight.pop_front();
          if (!m_killed && !flush) m_rq.push_back(inst_rdata);
        end
      end
      if (m_pend && inst_addr_ok) begin
        m_inflight.push_back(m_pend_killed);
        m_pend = 1'b0;
      end
      if (flush) begin
        m_rq.delete();
        foreach (m_inflight[i]) m_inflight[i] = 1'b1;
        if (m_pend) m_pend_killed = 1'b1;
      end
      if (m_exp_ack) begin
        m_pend = 1'b1;
        m_pend_addr = cpu_addr;
        m_pend_killed = 1'b0;
      end
    end
  end

  task automatic drive(input int req, input logic [31:0] addr, input int aok, input int dok,
                       input logic [31:0] rd, input int rdy, input int fl, input int st);
    cpu_req      = (req != 0);
    cpu_addr     = addr;
    inst_addr_ok = (aok != 0);
    inst_data_ok = (dok != 0);
    inst_rdata   = rd;
    cpu_rready   = (rdy != 0);
    flush        = (fl != 0);
    stall        = 4'(st);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int req, input logic [31:0] addr, input int aok, input int dok,
                               input logic [31:0] rd, input int rdy, input int fl, input int st);
    drive(req, addr, aok, dok, rd, rdy, fl, st);
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) tick();
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_inst_addr", inst_addr, 32'h0);
    rst = 1'b1;

    // Single fetch
    applyStimulus(1, 32'hBFC00000, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_req_c1", 32'(inst_req), 32'd1);
    checkOutput("t1_addr_c1", inst_addr, 32'hBFC00000);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
    checkOutput("t1_req_c3", 32'(inst_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h3C080001, 1, 0, 0);
    checkOutput("t1_rvalid_c5", 32'(cpu_rvalid), 32'd1);
    checkOutput("t1_rdata_c5", cpu_rdata, 32'h3C080001);
    checkOutput("t1_perr", 32'(proto_err), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_popped", 32'(cpu_rvalid), 32'd0);

    // Pipelined fetches, third one waits for a credit
    applyStimulus(1, 32'h00400000, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h00400004, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h00400004, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h00400008, 1, 0, 0, 1, 0, 0);
    drive(1, 32'h00400008, 0, 1, 32'h24080000, 1, 0, 0);
    #1 checkOutput("t2_ack_withheld", 32'(cpu_addr_ack), 32'd0);
    tick();
    checkOutput("t2_rdata0", cpu_rdata, 32'h24080000);
    drive(1, 32'h00400008, 0, 0, 0, 1, 0, 0);
    #1 checkOutput("t2_ack_fifo_credit", 32'(cpu_addr_ack), 32'd0);
    tick();
    drive(1, 32'h00400008, 0, 1, 32'h24090004, 1, 0, 0);
    #1 checkOutput("t2_ack_third", 32'(cpu_addr_ack), 32'd1);
    tick();
    checkOutput("t2_rdata1", cpu_rdata, 32'h24090004);
    checkOutput("t2_addr2", inst_addr, 32'h00400008);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h240A0008, 1, 0, 0);
    checkOutput("t2_rdata2", cpu_rdata, 32'h240A0008);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Backpressure fills the FIFO
    applyStimulus(1, 32'h00500000, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h00500004, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h00500004, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hE0E0E0E0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hE4E4E4E4, 0, 0, 0);
    drive(1, 32'h00500008, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("t3_ack_full", 32'(cpu_addr_ack), 32'd0);
    checkOutput("t3_inst_stall", 32'(inst_stall), 32'd0);
    tick();
    applyStimulus(1, 32'h00500008, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h00500008, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1 checkOutput("t3_head0", cpu_rdata, 32'hE0E0E0E0);
    tick();
    checkOutput("t3_head1", cpu_rdata, 32'hE4E4E4E4);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t3_drained_stall", 32'(inst_stall), 32'd1);

    // Flush with one outstanding and one pending without addr_ok
    applyStimulus(1, 32'h80000100, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h80000104, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("t4_req_held", 32'(inst_req), 32'd1);
    checkOutput("t4_addr_held", inst_addr, 32'h80000104);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hBAD00001, 1, 0, 0);
    drive(1, 32'h80000180, 0, 1, 32'hBAD00002, 1, 0, 0);
    #1 checkOutput("t4_ack_during_kill", 32'(cpu_addr_ack), 32'd1);
    tick();
    checkOutput("t4_dropped", 32'(cpu_rvalid), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h8C1A0068, 1, 0, 0);
    checkOutput("t4_post_flush_data", cpu_rdata, 32'h8C1A0068);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 32'h80000200, 0, 0, 0, 1, 1, 0);
    #1 checkOutput("t4_no_ack_on_flush", 32'(cpu_addr_ack), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Flush discards a buffered reply
    applyStimulus(1, 32'h00600000, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h11112222, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("t5_fifo_cleared", 32'(cpu_rvalid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Stall vector blocks issue but not returns
    applyStimulus(1, 32'h00700000, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
    drive(1, 32'h00700004, 0, 0, 0, 1, 0, 4'b0100);
    #1 checkOutput("t6_stall_ack", 32'(cpu_addr_ack), 32'd0);
    tick();
    checkOutput("t6_no_req", 32'(inst_req), 32'd0);
    applyStimulus(1, 32'h00700004, 0, 1, 32'h33334444, 1, 0, 4'b0100);
    checkOutput("t6_data_queued", cpu_rdata, 32'h33334444);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Spurious data_ok
    applyStimulus(0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0);
    checkOutput("t7_perr_set", 32'(proto_err), 32'd1);
    checkOutput("t7_no_push", 32'(cpu_rvalid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t7_perr_sticky", 32'(proto_err), 32'd1);

    // Asynchronous reset in the middle of a request
    applyStimulus(1, 32'h00800000, 0, 0, 0, 1, 0, 0);
    checkOutput("t8_req_before", 32'(inst_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("t8_async_req", 32'(inst_req), 32'd0);
    checkOutput("t8_async_addr", inst_addr, 32'h0);
    checkOutput("t8_async_perr", 32'(proto_err), 32'd0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t8_after_release", 32'(inst_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
